// File: rtl/main_memory_pkg.sv
// Shared definitions for the main memory capture path: FSM state codes,
// capture mode codes and small decode helpers.
package main_memory_pkg;

    // Capture sequencer state encoding
    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ARMED    = 3'd1;
    localparam logic [2:0] ST_CAP_BRAM = 3'd2;
    localparam logic [2:0] ST_CAP_SRAM = 3'd3;
    localparam logic [2:0] ST_DONE     = 3'd4;

    // Capture mode codes as written by the SPI register bank
    localparam logic [2:0] MODE_SINGLE = 3'b000;
    localparam logic [2:0] MODE_DUAL   = 3'b001;
    localparam logic [2:0] MODE_OCTAL  = 3'b011;
    localparam logic [2:0] MODE_HEX    = 3'b100;

    // Largest capture size exponent honoured (2^(16+8) samples)
    localparam int MAX_EXP = 16;

    function automatic logic mode_is_legal(input logic [2:0] m);
        return (m == MODE_SINGLE) || (m == MODE_DUAL) ||
               (m == MODE_OCTAL)  || (m == MODE_HEX);
    endfunction

    // Single/dual modes spill into the SRAM FIFO once BRAM is full
    function automatic logic mode_has_sram(input logic [2:0] m);
        return (m == MODE_SINGLE) || (m == MODE_DUAL);
    endfunction

    function automatic logic [4:0] clamp_exp(input logic [4:0] e);
        return (e > 5'(MAX_EXP)) ? 5'(MAX_EXP) : e;
    endfunction

endpackage

// File: rtl/main_memory_capture_controller_if.sv
// Control/status bundle between the SPI register bank, the trigger pin,
// the FIFOs and the capture sequencer.
// Handshake: arm and abort are single-cycle strobes sampled on the rising
// clock edge; sram_ready is a level that qualifies each SRAM beat, and a
// beat offered while it is low is dropped and flagged as overflow.
interface main_memory_capture_controller_if;
    logic       i_capture_ctrl_arm;
    logic       i_capture_ctrl_abort;
    logic [2:0] i_capture_ctrl_capture_mode;
    logic [4:0] i_capture_ctrl_capture_req_exp;
    logic       i_capture_ctrl_ext_trig;
    logic       i_capture_ctrl_ext_trig_en;
    logic       i_capture_ctrl_sram_ready;
    logic       o_capture_ctrl_bram_wr_clk_en;
    logic       o_capture_ctrl_sram_wr_clk_en;
    logic       o_capture_ctrl_busy;
    logic       o_capture_ctrl_done;
    logic       o_capture_ctrl_clipped;
    logic       o_capture_ctrl_overflow;
    logic       o_capture_ctrl_mode_err;
    logic [2:0] o_capture_ctrl_dbg_state;

    modport master (
        output i_capture_ctrl_arm, i_capture_ctrl_abort, i_capture_ctrl_capture_mode,
               i_capture_ctrl_capture_req_exp, i_capture_ctrl_ext_trig,
               i_capture_ctrl_ext_trig_en, i_capture_ctrl_sram_ready,
        input  o_capture_ctrl_bram_wr_clk_en, o_capture_ctrl_sram_wr_clk_en,
               o_capture_ctrl_busy, o_capture_ctrl_done, o_capture_ctrl_clipped,
               o_capture_ctrl_overflow, o_capture_ctrl_mode_err, o_capture_ctrl_dbg_state
    );

    modport slave (
        input  i_capture_ctrl_arm, i_capture_ctrl_abort, i_capture_ctrl_capture_mode,
               i_capture_ctrl_capture_req_exp, i_capture_ctrl_ext_trig,
               i_capture_ctrl_ext_trig_en, i_capture_ctrl_sram_ready,
        output o_capture_ctrl_bram_wr_clk_en, o_capture_ctrl_sram_wr_clk_en,
               o_capture_ctrl_busy, o_capture_ctrl_done, o_capture_ctrl_clipped,
               o_capture_ctrl_overflow, o_capture_ctrl_mode_err, o_capture_ctrl_dbg_state
    );
endinterface

// File: rtl/capture_trig_sync.sv
// Brings the asynchronous SMA trigger into the write clock domain and
// produces a one-cycle pulse on its synchronised rising edge.
module capture_trig_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic trig_async,
    output logic trig_rise
);
    // [0],[1] form the synchroniser, [2] holds the previous synced level
    logic [2:0] sync_q;

    // Shift the pin through the synchroniser and edge-history flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 3'b000;
        end else begin
            sync_q <= {sync_q[1:0], trig_async};
        end
    end

    assign trig_rise = sync_q[1] & ~sync_q[2];
endmodule

// File: rtl/main_memory_capture_controller.sv
// Write-side capture sequencer: arms on request, optionally waits for the
// external trigger, then issues exactly total_beats write slots, BRAM first
// and SRAM after (SRAM-capable modes), and reports status to SPI.
module main_memory_capture_controller
    import main_memory_pkg::*;
#(
    parameter int WORDS_PER_BEAT_LOG2 = 3,
    parameter int BRAM_DEPTH_BEATS    = 32768,
    parameter int BEAT_CNT_W          = 22
) (
    input  logic                             i_capture_ctrl_clk,
    input  logic                             i_capture_ctrl_reset_n,
    main_memory_capture_controller_if.slave  bus
);
    localparam logic [BEAT_CNT_W-1:0] ONE   = {{(BEAT_CNT_W-1){1'b0}}, 1'b1};
    localparam logic [BEAT_CNT_W-1:0] DEPTH = BEAT_CNT_W'(BRAM_DEPTH_BEATS);

    logic [2:0]            state_q, state_d;
    logic [BEAT_CNT_W-1:0] beat_q, beat_d;
    logic [BEAT_CNT_W-1:0] total_q, total_d;
    logic [2:0]            mode_q, mode_d;
    logic                  trig_en_q, trig_en_d;
    logic                  clipped_q, clipped_d;
    logic                  overflow_q, overflow_d;
    logic                  mode_err_d;
    logic                  trig_rise;

    logic [4:0]            arm_exp;
    logic [5:0]            arm_shift;
    logic [BEAT_CNT_W-1:0] arm_beats;
    logic                  arm_clip;
    logic [BEAT_CNT_W-1:0] bram_lim;

    capture_trig_sync u_trig_sync (
        .clk        (i_capture_ctrl_clk),
        .rst_n      (i_capture_ctrl_reset_n),
        .trig_async (bus.i_capture_ctrl_ext_trig),
        .trig_rise  (trig_rise)
    );

    // Capture size and clipping derived from the request presented with arm
    always_comb begin
        arm_exp   = clamp_exp(bus.i_capture_ctrl_capture_req_exp);
        arm_shift = 6'(arm_exp) + 6'd8 - 6'(WORDS_PER_BEAT_LOG2);
        arm_beats = ONE << arm_shift;
        arm_clip  = !mode_has_sram(bus.i_capture_ctrl_capture_mode) && (arm_beats > DEPTH);
        bram_lim  = (total_q < DEPTH) ? total_q : DEPTH;
    end

    // Next-state logic; beat_q counts write slots already issued
    always_comb begin
        state_d    = state_q;
        beat_d     = beat_q;
        total_d    = total_q;
        mode_d     = mode_q;
        trig_en_d  = trig_en_q;
        clipped_d  = clipped_q;
        overflow_d = overflow_q;
        mode_err_d = 1'b0;
        if (bus.i_capture_ctrl_abort) begin
            // abort beats any arm in the same cycle
            state_d = ST_IDLE;
            beat_d  = '0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (bus.i_capture_ctrl_arm) begin
                        if (mode_is_legal(bus.i_capture_ctrl_capture_mode)) begin
                            state_d    = ST_ARMED;
                            beat_d     = '0;
                            mode_d     = bus.i_capture_ctrl_capture_mode;
                            trig_en_d  = bus.i_capture_ctrl_ext_trig_en;
                            total_d    = arm_clip ? DEPTH : arm_beats;
                            clipped_d  = arm_clip;
                            overflow_d = 1'b0;
                        end else begin
                            mode_err_d = 1'b1;
                        end
                    end
                end
                ST_ARMED: begin
                    if (!trig_en_q || trig_rise) begin
                        state_d = ST_CAP_BRAM;
                        beat_d  = ONE;
                    end
                end
                ST_CAP_BRAM: begin
                    if (beat_q == bram_lim) begin
                        if (mode_has_sram(mode_q) && (beat_q != total_q)) begin
                            state_d = ST_CAP_SRAM;
                            beat_d  = beat_q + ONE;
                        end else begin
                            state_d = ST_DONE;
                        end
                    end else begin
                        beat_d = beat_q + ONE;
                    end
                end
                ST_CAP_SRAM: begin
                    if (beat_q == total_q) begin
                        state_d = ST_DONE;
                    end else begin
                        beat_d = beat_q + ONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
        // an SRAM slot issued while the FIFO cannot accept it is lost
        if ((state_d == ST_CAP_SRAM) && !bus.i_capture_ctrl_sram_ready) begin
            overflow_d = 1'b1;
        end
    end

    // State, counters and registered status/enable outputs
    always_ff @(posedge i_capture_ctrl_clk or negedge i_capture_ctrl_reset_n) begin
        if (!i_capture_ctrl_reset_n) begin
            state_q                       <= ST_IDLE;
            beat_q                        <= '0;
            total_q                       <= '0;
            mode_q                        <= MODE_SINGLE;
            trig_en_q                     <= 1'b0;
            clipped_q                     <= 1'b0;
            overflow_q                    <= 1'b0;
            bus.o_capture_ctrl_bram_wr_clk_en <= 1'b0;
            bus.o_capture_ctrl_sram_wr_clk_en <= 1'b0;
            bus.o_capture_ctrl_busy       <= 1'b0;
            bus.o_capture_ctrl_done       <= 1'b0;
            bus.o_capture_ctrl_mode_err   <= 1'b0;
        end else begin
            state_q                       <= state_d;
            beat_q                        <= beat_d;
            total_q                       <= total_d;
            mode_q                        <= mode_d;
            trig_en_q                     <= trig_en_d;
            clipped_q                     <= clipped_d;
            overflow_q                    <= overflow_d;
            bus.o_capture_ctrl_bram_wr_clk_en <= (state_d == ST_CAP_BRAM);
            bus.o_capture_ctrl_sram_wr_clk_en <= (state_d == ST_CAP_SRAM) &&
                                                 bus.i_capture_ctrl_sram_ready;
            bus.o_capture_ctrl_busy       <= (state_d == ST_ARMED) || (state_d == ST_CAP_BRAM) ||
                                             (state_d == ST_CAP_SRAM);
            bus.o_capture_ctrl_done       <= (state_d == ST_DONE);
            bus.o_capture_ctrl_mode_err   <= mode_err_d;
        end
    end

    assign bus.o_capture_ctrl_clipped   = clipped_q;
    assign bus.o_capture_ctrl_overflow  = overflow_q;
    assign bus.o_capture_ctrl_dbg_state = state_q;
endmodule

// File: tb/tb_main_memory_capture_controller.sv
// Bench for the capture sequencer: two instances (full-size BRAM and a
// 16-beat BRAM) share one stimulus stream, each checked per cycle against
// a slot schedule derived from the capture size rules.
module tb_main_memory_capture_controller;
    import main_memory_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;

    // clock
    always #5 clk = ~clk;

    main_memory_capture_controller_if bus_a ();
    main_memory_capture_controller_if bus_b ();

    assign bus_b.i_capture_ctrl_arm             = bus_a.i_capture_ctrl_arm;
    assign bus_b.i_capture_ctrl_abort           = bus_a.i_capture_ctrl_abort;
    assign bus_b.i_capture_ctrl_capture_mode    = bus_a.i_capture_ctrl_capture_mode;
    assign bus_b.i_capture_ctrl_capture_req_exp = bus_a.i_capture_ctrl_capture_req_exp;
    assign bus_b.i_capture_ctrl_ext_trig        = bus_a.i_capture_ctrl_ext_trig;
    assign bus_b.i_capture_ctrl_ext_trig_en     = bus_a.i_capture_ctrl_ext_trig_en;
    assign bus_b.i_capture_ctrl_sram_ready      = bus_a.i_capture_ctrl_sram_ready;

    main_memory_capture_controller #(.BRAM_DEPTH_BEATS(32768)) dut_a (
        .i_capture_ctrl_clk     (clk),
        .i_capture_ctrl_reset_n (rst_n),
        .bus                    (bus_a.slave)
    );

    main_memory_capture_controller #(.BRAM_DEPTH_BEATS(16)) dut_b (
        .i_capture_ctrl_clk     (clk),
        .i_capture_ctrl_reset_n (rst_n),
        .bus                    (bus_b.slave)
    );

    // status bits: 0 bram_en, 1 sram_en, 2 busy, 3 done, 4 clipped, 5 overflow, 6 mode_err
    logic [6:0] st_a, st_b;
    assign st_a = {bus_a.o_capture_ctrl_mode_err, bus_a.o_capture_ctrl_overflow,
                   bus_a.o_capture_ctrl_clipped, bus_a.o_capture_ctrl_done,
                   bus_a.o_capture_ctrl_busy, bus_a.o_capture_ctrl_sram_wr_clk_en,
                   bus_a.o_capture_ctrl_bram_wr_clk_en};
    assign st_b = {bus_b.o_capture_ctrl_mode_err, bus_b.o_capture_ctrl_overflow,
                   bus_b.o_capture_ctrl_clipped, bus_b.o_capture_ctrl_done,
                   bus_b.o_capture_ctrl_busy, bus_b.o_capture_ctrl_sram_wr_clk_en,
                   bus_b.o_capture_ctrl_bram_wr_clk_en};

    // scoreboard: expected {sram_en, bram_en} per write slot
    logic [1:0] exp_a_q[$];
    logic [1:0] exp_b_q[$];
    bit         rdy_pat [0:1023];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_quiet(input string tag, input bit busy);
        check({tag, "_en_a"}, 32'(st_a[1:0]), 32'd0);
        check({tag, "_en_b"}, 32'(st_b[1:0]), 32'd0);
        check({tag, "_busy_a"}, 32'(st_a[2]), 32'(busy));
        check({tag, "_busy_b"}, 32'(st_b[2]), 32'(busy));
    endtask

    task automatic arm(input logic [2:0] mode, input logic [4:0] exp, input bit trig_en);
        bus_a.i_capture_ctrl_capture_mode    = mode;
        bus_a.i_capture_ctrl_capture_req_exp = exp;
        bus_a.i_capture_ctrl_ext_trig_en     = trig_en;
        bus_a.i_capture_ctrl_arm             = 1'b1;
        tick();
        bus_a.i_capture_ctrl_arm = 1'b0;
    endtask

    // rdy_kind: 0 always ready, 1 three-cycle stall in dut_b's SRAM phase, 2 random
    task automatic run_capture(input string name, input logic [2:0] mode, input logic [4:0] exp,
                               input bit trig, input int rdy_kind);
        int depth [2];
        int tot [2];
        int lim [2];
        int n_sram [2];
        int e_sram [2];
        bit clip [2];
        bit ovf [2];
        int eff, base, tmax, s;
        bit sram_ok;
        logic [1:0] e;
        depth[0] = 32768;
        depth[1] = 16;
        eff     = (exp > 5'd16) ? 16 : int'(exp);
        base    = 1 << (eff + 8 - 3);
        sram_ok = (mode == MODE_SINGLE) || (mode == MODE_DUAL);
        for (int d = 0; d < 2; d++) begin
            clip[d]   = !sram_ok && (base > depth[d]);
            tot[d]    = clip[d] ? depth[d] : base;
            lim[d]    = (tot[d] < depth[d]) ? tot[d] : depth[d];
            n_sram[d] = 0;
        end
        tmax = (tot[0] > tot[1]) ? tot[0] : tot[1];
        for (int k = 0; k < tmax; k++) begin
            rdy_pat[k] = (rdy_kind == 2) ? ($urandom_range(0, 3) != 0) : 1'b1;
        end
        if (rdy_kind == 1) begin
            s = 16 + int'($urandom_range(0, 13));
            for (int k = s; k < s + 3; k++) rdy_pat[k] = 1'b0;
        end
        exp_a_q.delete();
        exp_b_q.delete();
        for (int d = 0; d < 2; d++) begin
            ovf[d]    = 1'b0;
            e_sram[d] = 0;
            for (int k = 0; k < tot[d]; k++) begin
                e = {(k >= lim[d]) && rdy_pat[k], k < lim[d]};
                if (d == 0) exp_a_q.push_back(e);
                else        exp_b_q.push_back(e);
                if (k >= lim[d]) begin
                    if (rdy_pat[k]) e_sram[d]++;
                    else            ovf[d] = 1'b1;
                end
            end
        end

        if (trig) begin
            bus_a.i_capture_ctrl_ext_trig = 1'b1;
            repeat (3) tick();
        end
        arm(mode, exp, trig);
        check_quiet({name, "_armed"}, 1'b1);
        check({name, "_done_clr_a"}, 32'(st_a[3]), 32'd0);
        check({name, "_done_clr_b"}, 32'(st_b[3]), 32'd0);
        if (trig) begin
            repeat ($urandom_range(2, 5)) begin
                tick();
                check_quiet({name, "_trig_level"}, 1'b1);
            end
            bus_a.i_capture_ctrl_ext_trig = 1'b0;
            repeat (3) begin
                tick();
                check_quiet({name, "_trig_low"}, 1'b1);
            end
            bus_a.i_capture_ctrl_ext_trig = 1'b1;
            repeat (2) begin
                tick();
                check_quiet({name, "_trig_sync"}, 1'b1);
            end
        end
        bus_a.i_capture_ctrl_sram_ready = rdy_pat[0];
        tick();
        for (int k = 0; k <= tmax; k++) begin
            e = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : 2'b00;
            check({name, "_slot_a"}, 32'(st_a[1:0]), 32'(e));
            check({name, "_busy_a"}, 32'(st_a[2]), 32'(k < tot[0]));
            check({name, "_done_a"}, 32'(st_a[3]), 32'(k >= tot[0]));
            e = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 2'b00;
            check({name, "_slot_b"}, 32'(st_b[1:0]), 32'(e));
            check({name, "_busy_b"}, 32'(st_b[2]), 32'(k < tot[1]));
            check({name, "_done_b"}, 32'(st_b[3]), 32'(k >= tot[1]));
            n_sram[0] += int'(st_a[1]);
            n_sram[1] += int'(st_b[1]);
            if (k == tmax) break;
            if (k == 2) begin
                // a second arm while busy must not disturb the capture
                bus_a.i_capture_ctrl_capture_mode    = MODE_SINGLE;
                bus_a.i_capture_ctrl_capture_req_exp = 5'd4;
                bus_a.i_capture_ctrl_arm             = 1'b1;
            end
            bus_a.i_capture_ctrl_sram_ready = (k + 1 < tmax) ? rdy_pat[k + 1] : 1'b1;
            tick();
            bus_a.i_capture_ctrl_arm = 1'b0;
        end
        check({name, "_clip_a"}, 32'(st_a[4]), 32'(clip[0]));
        check({name, "_clip_b"}, 32'(st_b[4]), 32'(clip[1]));
        check({name, "_ovf_a"}, 32'(st_a[5]), 32'(ovf[0]));
        check({name, "_ovf_b"}, 32'(st_b[5]), 32'(ovf[1]));
        check({name, "_nsram_a"}, 32'(n_sram[0]), 32'(e_sram[0]));
        check({name, "_nsram_b"}, 32'(n_sram[1]), 32'(e_sram[1]));
    endtask

    // reset, directed cases, random cases, report
    initial begin
        logic [2:0] legal_modes [4];
        legal_modes[0] = MODE_SINGLE;
        legal_modes[1] = MODE_DUAL;
        legal_modes[2] = MODE_OCTAL;
        legal_modes[3] = MODE_HEX;

        bus_a.i_capture_ctrl_arm             = 1'b0;
        bus_a.i_capture_ctrl_abort           = 1'b0;
        bus_a.i_capture_ctrl_capture_mode    = MODE_SINGLE;
        bus_a.i_capture_ctrl_capture_req_exp = 5'd0;
        bus_a.i_capture_ctrl_ext_trig        = 1'b0;
        bus_a.i_capture_ctrl_ext_trig_en     = 1'b0;
        bus_a.i_capture_ctrl_sram_ready      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_status_a", 32'(st_a), 32'd0);
        check("reset_status_b", 32'(st_b), 32'd0);
        check("reset_state_a", 32'(bus_a.o_capture_ctrl_dbg_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        tick();

        run_capture("bram_only", MODE_OCTAL, 5'd0, 1'b0, 0);
        run_capture("bram_sram", MODE_SINGLE, 5'd0, 1'b0, 0);
        run_capture("clip_hex", MODE_HEX, 5'd0, 1'b0, 0);
        run_capture("trig", MODE_DUAL, 5'd0, 1'b1, 0);
        run_capture("sram_stall", MODE_SINGLE, 5'd0, 1'b0, 1);
        for (int i = 0; i < 4; i++) begin
            run_capture("rand", legal_modes[$urandom_range(0, 3)], 5'($urandom_range(0, 3)),
                        1'($urandom_range(0, 1)), 2);
        end

        // abort in DONE clears done
        bus_a.i_capture_ctrl_abort = 1'b1;
        tick();
        bus_a.i_capture_ctrl_abort = 1'b0;
        check("abort_done_a", 32'(st_a[3]), 32'd0);
        check("abort_done_b", 32'(st_b[3]), 32'd0);
        check("abort_done_state", 32'(bus_a.o_capture_ctrl_dbg_state), 32'(ST_IDLE));

        // abort mid BRAM capture
        arm(MODE_OCTAL, 5'd0, 1'b0);
        repeat (6) tick();
        check("pre_abort_bram_a", 32'(st_a[0]), 32'd1);
        bus_a.i_capture_ctrl_abort = 1'b1;
        tick();
        bus_a.i_capture_ctrl_abort = 1'b0;
        check_quiet("abort_cap", 1'b0);
        check("abort_cap_done_a", 32'(st_a[3]), 32'd0);
        check("abort_cap_done_b", 32'(st_b[3]), 32'd0);

        // abort wins over a simultaneous arm
        bus_a.i_capture_ctrl_abort = 1'b1;
        arm(MODE_OCTAL, 5'd0, 1'b0);
        bus_a.i_capture_ctrl_abort = 1'b0;
        check_quiet("arm_abort", 1'b0);

        // illegal mode pulses mode_err for one cycle only
        arm(3'b111, 5'd0, 1'b0);
        check("mode_err_a", 32'(st_a[6]), 32'd1);
        check("mode_err_b", 32'(st_b[6]), 32'd1);
        check_quiet("mode_err", 1'b0);
        tick();
        check("mode_err_end_a", 32'(st_a[6]), 32'd0);
        check_quiet("mode_err_end", 1'b0);

        // exp above 16 clamps to 16: 2^21 beats clips both BRAM-only instances
        arm(MODE_OCTAL, 5'd31, 1'b0);
        check("exp31_clip_a", 32'(st_a[4]), 32'd1);
        check("exp31_clip_b", 32'(st_b[4]), 32'd1);
        check("exp31_busy_a", 32'(st_a[2]), 32'd1);
        bus_a.i_capture_ctrl_abort = 1'b1;
        tick();
        bus_a.i_capture_ctrl_abort = 1'b0;
        check_quiet("exp31_abort", 1'b0);

        // asynchronous reset mid capture drops the enables at once
        arm(MODE_OCTAL, 5'd0, 1'b0);
        repeat (3) tick();
        check("pre_reset_bram_b", 32'(st_b[0]), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_quiet("async_reset", 1'b0);
        check("async_reset_state", 32'(bus_b.o_capture_ctrl_dbg_state), 32'(ST_IDLE));
        #2;
        rst_n = 1'b1;
        tick();
        check_quiet("post_reset", 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/main_memory_capture_controller.md
Name: main_memory_capture_controller

Overview:
Write-side sequencer for the main memory capture path, running in the ADC write clock domain. On an arm request it latches the capture configuration and optionally waits for an external trigger. It then counts the requested capture length and steers write beats to the BRAM FIFO first, then to the SRAM FIFO (SRAM-capable modes only), driving the BRAM and SRAM write clock enables. It reports busy, done, clip and overflow status back to the SPI register bank.

Parameters:
WORDS_PER_BEAT_LOG2, 3, log2 of samples written per enabled clock (8 = BRAM_WORD_NUM); legal range 2..6
BRAM_DEPTH_BEATS, 32768, BRAM FIFO capacity in beats (256k samples / 8)
BEAT_CNT_W, 22, beat counter width; must hold 2^(24-WORDS_PER_BEAT_LOG2)

Ports:
i_capture_ctrl_clk  in  1  write clock (same net as the main memory write clock)
i_capture_ctrl_reset_n  in  1  reset, asynchronous, active-low
i_capture_ctrl_arm  in  1  single-cycle start request from SPI
i_capture_ctrl_abort  in  1  single-cycle abort request
i_capture_ctrl_capture_mode  in  3  000/001 = BRAM+SRAM; 011/100 = BRAM only; other codes illegal
i_capture_ctrl_capture_req_exp  in  5  capture size = 2^(exp+8) samples; values >16 clamp to 16
i_capture_ctrl_ext_trig  in  1  asynchronous external trigger (SMA)
i_capture_ctrl_ext_trig_en  in  1  external trigger enable
i_capture_ctrl_sram_ready  in  1  SRAM FIFO able to accept a beat
o_capture_ctrl_bram_wr_clk_en  out  1  BRAM FIFO write enable
o_capture_ctrl_sram_wr_clk_en  out  1  SRAM FIFO write enable
o_capture_ctrl_busy  out  1  high in ARMED/CAP_BRAM/CAP_SRAM
o_capture_ctrl_done  out  1  high in DONE
o_capture_ctrl_clipped  out  1  request exceeded BRAM capacity in a BRAM-only mode
o_capture_ctrl_overflow  out  1  at least one SRAM beat lost (sram_ready low)
o_capture_ctrl_mode_err  out  1  one-cycle pulse when arm is given with an illegal mode

Behaviour:
- Reset: all outputs 0, state IDLE, counters 0, trigger synchroniser cleared.
- States: IDLE, ARMED, CAP_BRAM, CAP_SRAM, DONE.
- IDLE/DONE + arm + legal mode:
  - latch mode and clamped exp;
  - total_beats = 1 << (exp+8-WORDS_PER_BEAT_LOG2);
  - BRAM-only mode with total_beats > BRAM_DEPTH_BEATS: total_beats = BRAM_DEPTH_BEATS, clipped=1, else clipped=0;
  - clear done and overflow; go to ARMED.
- Arm with illegal mode: mode_err pulses on the next cycle; state unchanged.
- Arm while busy: ignored.
- ext_trig passes through a 2-FF synchroniser; rising edge detected on the synchronised signal.
- ARMED:
  - ext_trig_en latched at arm = 0: leave after one cycle.
  - ext_trig_en = 1: wait for a rising edge (a level already high at arm does not trigger).
  - Go to CAP_BRAM.
- Timing, trigger disabled: arm sampled at edge 0; ARMED during cycle 1; first bram_wr_clk_en high in cycle 2.
- Timing, trigger enabled: first beat 1 cycle after the edge is detected (3 cycles after the raw pin edge).
- CAP_BRAM: bram_wr_clk_en=1 every cycle; beat_cnt increments.
  - Exit when beat_cnt reaches min(total_beats, BRAM_DEPTH_BEATS).
  - Exit to CAP_SRAM if the mode is SRAM-capable and beats remain, else to DONE.
  - No idle cycle between the last BRAM beat and the first SRAM beat.
- CAP_SRAM: sram_wr_clk_en = sram_ready. beat_cnt increments every cycle regardless, so capture time is fixed. A cycle with sram_ready=0 sets sticky overflow. Go to DONE when beat_cnt = total_beats.
- Exactly total_beats enable cycles total (BRAM+SRAM slots); enables are registered outputs, never glitch.
- abort:
  - In any state except IDLE: go to IDLE next cycle, enables drop that cycle, done stays 0.
  - Simultaneous with arm: abort wins.
  - Abort in DONE clears done.
- Reset mid-capture: enables drop immediately (asynchronous); state goes to IDLE.
- Counter compare uses the full BEAT_CNT_W width; no wrap (max 2^21 beats < 2^22).

Decomposition:
- Package main_memory_pkg: capture state encoding, mode code constants (MODE_SINGLE=3'b000, MODE_DUAL=3'b001, MODE_OCTAL=3'b011, MODE_HEX=3'b100), MAX_EXP=16.
- One sub-module, capture_trig_sync: 2-FF synchroniser plus rising-edge detector with async active-low reset.

Test Plan:
- Mode 011, exp=0, trig disabled, default params, arm: 32 contiguous bram_wr_clk_en cycles 2..33; done=1 from cycle 34; sram_wr_clk_en never high; clipped=0.
- BRAM_DEPTH_BEATS=16, mode 000, exp=0: 16 BRAM beats then 16 contiguous SRAM beats; done after beat 32; overflow=0.
- BRAM_DEPTH_BEATS=16, mode 100, exp=0: clipped=1; exactly 16 BRAM beats; then done.
- Trig enabled with ext_trig held high at arm: no capture; pulse ext_trig low then high; first BRAM beat 3 cycles after the rising edge.
- Mode 000, BRAM_DEPTH_BEATS=16, sram_ready low for 3 cycles in CAP_SRAM: 13 SRAM enables; overflow=1; done still at beat 32.
- Abort at BRAM beat 5 → enables low next cycle, busy=0, done=0. Arm with mode 111 → mode_err one-cycle pulse, busy stays 0. Exp=31 → treated as 16.
